sipo_20bit_rx: RTL and testbench

Serial-in/parallel-out receiver; the far end of the 20-bit PISO serial link. It samples s_in on clk edges where shift=1, LSB first, and assembles a WIDTH-bit word. It presents each completed word on a held parallel output with a valid/ack handshake and flags overruns. It sits at the receiving side of the serial interface, feeding a downstream consumer.

---
 rtl/sipo_20bit_rx_if.sv | 26 ++
 rtl/sipo_20bit_rx.sv | 107 ++++++++++
 tb/tb_sipo_20bit_rx.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_20bit_rx_if.sv
// Handshake and serial-link bundle for the 20-bit SIPO receiver.
// The master drives the serial strobes and the acknowledge. The slave (the receiver) returns the word and its status.
interface sipo_20bit_rx_if #(
  parameter int WIDTH = 20,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             shift;
  logic             s_in;
  logic             clear;
  logic             p_ack;
  logic [WIDTH-1:0] p_out;
  logic             p_valid;
  logic             overrun;
  logic [CNT_W-1:0] bit_cnt;
  logic             par_err;

  modport master (
    output shift, s_in, clear, p_ack,
    input  p_out, p_valid, overrun, bit_cnt, par_err
  );

  modport slave (
    input  shift, s_in, clear, p_ack,
    output p_out, p_valid, overrun, bit_cnt, par_err
  );
endinterface

// File: rtl/sipo_20bit_rx.sv
// Serial-in/parallel-out receiver for the 20-bit PISO link: LSB-first assembly, valid/ack output, sticky overrun.
// Optional trailing even-parity bit and par_err flag when SIPO_RX_PARITY_EN is defined.
module sipo_20bit_rx #(
  parameter int WIDTH = 20
) (
  input logic            clk,
  input logic            rst_n,
  sipo_20bit_rx_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef SIPO_RX_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
  localparam int SREG_W     = WIDTH;
`else
  // The final data bit goes straight into p_out, so only WIDTH-1 bits need staging.
  localparam int FRAME_BITS = WIDTH;
  localparam int SREG_W     = WIDTH - 1;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  logic [SREG_W-1:0] sreg;
  logic [SREG_W-1:0] sreg_shifted;
  logic [WIDTH-1:0]  word_next;
  logic [WIDTH-1:0]  p_out_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic              p_valid_r;
  logic              overrun_r;
  logic              complete;
  logic              load;

  always_comb begin
    sreg_shifted = {bus.s_in, sreg[SREG_W-1:1]};
    complete     = bus.shift && (bit_cnt_r == LAST_CNT);
    load         = complete && !bus.clear;
`ifdef SIPO_RX_PARITY_EN
    word_next    = sreg;
`else
    word_next    = {bus.s_in, sreg};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg      <= '0;
      bit_cnt_r <= '0;
    end else if (bus.clear) begin
      sreg      <= '0;
      bit_cnt_r <= '0;
    end else if (bus.shift) begin
      if (complete) begin
        sreg      <= '0;
        bit_cnt_r <= '0;
      end else begin
        sreg      <= sreg_shifted;
        bit_cnt_r <= bit_cnt_r + 1'b1;
      end
    end
  end

  // A completion always wins over an ack on the same edge.
  // The old word is replaced, and overrun is only flagged when it was never acknowledged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_out_r   <= '0;
      p_valid_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (load) begin
        p_out_r   <= word_next;
        p_valid_r <= 1'b1;
      end else if (p_valid_r && bus.p_ack) begin
        p_valid_r <= 1'b0;
      end

      if (bus.clear) begin
        overrun_r <= 1'b0;
      end else if (load && p_valid_r && !bus.p_ack) begin
        overrun_r <= 1'b1;
      end
    end
  end

`ifdef SIPO_RX_PARITY_EN
  logic par_err_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_err_r <= 1'b0;
    end else if (load) begin
      par_err_r <= (^sreg) ^ bus.s_in;
    end
  end

  assign bus.par_err = par_err_r;
`else
  assign bus.par_err = 1'b0;
`endif

  assign bus.p_out   = p_out_r;
  assign bus.p_valid = p_valid_r;
  assign bus.overrun = overrun_r;
  assign bus.bit_cnt = bit_cnt_r;

endmodule

// File: tb/tb_sipo_20bit_rx.sv
// Self-checking bench for sipo_20bit_rx: a vector table, directed frame sequences and random traffic.
// A queue-based frame model checks the design after every clock edge.
module tb_sipo_20bit_rx;

  localparam int WIDTH = 20;
`ifdef SIPO_RX_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sipo_20bit_rx_if #(.WIDTH(WIDTH)) bus();

  sipo_20bit_rx #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  bit               m_bits[$];
  logic [WIDTH-1:0] m_out;
  bit               m_valid;
  bit               m_ovr;
  bit               m_par;

  typedef struct {
    bit rst_n;
    bit shift;
    bit s_in;
    bit clear;
    bit ack;
    bit exp_valid;
    int exp_cnt;
    bit exp_ovr;
  } vec_t;

  vec_t vecs[10];

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name);
    tests_run++;
    if (bus.p_out !== m_out || bus.p_valid !== m_valid || bus.overrun !== m_ovr ||
        32'(bus.bit_cnt) !== 32'(m_bits.size()) || bus.par_err !== m_par) begin
      tests_failed++;
      $display("[TB] FAIL %s @%0t: got out=%h valid=%b ovr=%b cnt=%0d par=%b, expected out=%h valid=%b ovr=%b cnt=%0d par=%b",
               name, $time, bus.p_out, bus.p_valid, bus.overrun, bus.bit_cnt, bus.par_err,
               m_out, m_valid, m_ovr, m_bits.size(), m_par);
    end
  endtask

  // Reference behaviour for one clock edge.
  // Bits are collected in arrival order, and a finished frame is summed into a word.
  task automatic modelEdge(input bit r, input bit s, input bit d, input bit c, input bit a);
    bit               done;
    int               ones;
    logic [WIDTH-1:0] w;
    done = 1'b0;
    ones = 0;
    w    = '0;
    if (!r) begin
      m_bits.delete();
      m_out   = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_par   = 1'b0;
    end else if (c) begin
      m_bits.delete();
      m_ovr = 1'b0;
      if (m_valid && a) m_valid = 1'b0;
    end else begin
      if (s) begin
        m_bits.push_back(d);
        if (m_bits.size() == FRAME_BITS) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (m_bits[i]) begin
              w    = w + (WIDTH'(1) << i);
              ones = ones + 1;
            end
          end
          if (FRAME_BITS > WIDTH) m_par = ((ones + int'(m_bits[WIDTH])) % 2) != 0;
          else                    m_par = 1'b0;
          if (m_valid && !a) m_ovr = 1'b1;
          m_out   = w;
          m_valid = 1'b1;
          m_bits.delete();
          done = 1'b1;
        end
      end
      if (!done && m_valid && a) m_valid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit d, input bit c, input bit a);
    rst_n     = r;
    bus.shift = s;
    bus.s_in  = d;
    bus.clear = c;
    bus.p_ack = a;
    modelEdge(r, s, d, c, a);
    @(posedge clk);
    #1;
    checkOutput("model");
  endtask

  // Sends one frame, LSB first. It can insert 3-cycle gaps after the given bit counts,
  // and it can raise p_ack on the completing edge.
  task automatic sendWord(input logic [WIDTH-1:0] word, input bit par, input int gap_a,
                          input int gap_b, input bit ack_last);
    for (int i = 0; i < WIDTH; i++) begin
      applyStimulus(1'b1, 1'b1, word[i], 1'b0, ack_last && (FRAME_BITS == WIDTH) && (i == WIDTH - 1));
      if (i + 1 == gap_a || i + 1 == gap_b) begin
        for (int g = 0; g < 3; g++) begin
          applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
          checkValue("gap_cnt", 32'(bus.bit_cnt), 32'(i + 1));
        end
      end
    end
    if (FRAME_BITS > WIDTH) applyStimulus(1'b1, 1'b1, par, 1'b0, ack_last);
  endtask

  task automatic checkAll(input string name, input logic [WIDTH-1:0] out, input bit valid,
                          input int cnt, input bit ovr);
    checkValue({name, "_p_out"},   32'(bus.p_out),   32'(out));
    checkValue({name, "_p_valid"}, 32'(bus.p_valid), 32'(valid));
    checkValue({name, "_bit_cnt"}, 32'(bus.bit_cnt), 32'(cnt));
    checkValue({name, "_overrun"}, 32'(bus.overrun), 32'(ovr));
  endtask

  initial begin
    logic [WIDTH-1:0] w1;
    logic [WIDTH-1:0] w2;
    logic [WIDTH-1:0] w3;
    w1 = 20'h06850;
    w2 = 20'hFFFFF;
    w3 = 20'h12345;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkAll("reset", '0, 1'b0, 0, 1'b0);
    checkValue("reset_par_err", 32'(bus.par_err), 32'd0);

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].shift, vecs[i].s_in, vecs[i].clear, vecs[i].ack);
      checkValue($sformatf("vec%0d_valid", i), 32'(bus.p_valid), 32'(vecs[i].exp_valid));
      checkValue($sformatf("vec%0d_cnt", i),   32'(bus.bit_cnt), 32'(vecs[i].exp_cnt));
      checkValue($sformatf("vec%0d_ovr", i),   32'(bus.overrun), 32'(vecs[i].exp_ovr));
    end

    sendWord(w1, ^w1, 0, 0, 1'b0);
    checkAll("frame", w1, 1'b1, 0, 1'b0);
    checkValue("frame_par_err", 32'(bus.par_err), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkValue("ack_valid", 32'(bus.p_valid), 32'd0);

    sendWord(w1, ^w1, 5, 13, 1'b0);
    checkAll("gaps", w1, 1'b1, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    sendWord(w1, ^w1, 0, 0, 1'b0);
    sendWord(w2, ^w2, 0, 0, 1'b1);
    checkAll("b2b_ack", w2, 1'b1, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    sendWord(w1, ^w1, 0, 0, 1'b0);
    sendWord(w2, ^w2, 0, 0, 1'b0);
    checkAll("b2b_noack", w2, 1'b1, 0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("ovr_clear", w2, 1'b1, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkValue("ovr_ack_valid", 32'(bus.p_valid), 32'd0);

    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkAll("abort_clear", w2, 1'b0, 0, 1'b0);
    sendWord(w3, ^w3, 0, 0, 1'b0);
    checkAll("after_clear", w3, 1'b1, 0, 1'b0);

    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkAll("abort_reset", '0, 1'b0, 0, 1'b0);
    for (int i = 0; i < WIDTH - 1; i++) applyStimulus(1'b1, 1'b1, w3[i], 1'b0, 1'b0);
    checkValue("pre_done_valid", 32'(bus.p_valid), 32'd0);
    checkValue("pre_done_p_out", 32'(bus.p_out), 32'd0);
    applyStimulus(1'b1, 1'b1, w3[WIDTH-1], 1'b0, 1'b0);
    if (FRAME_BITS > WIDTH) applyStimulus(1'b1, 1'b1, ^w3, 1'b0, 1'b0);
    checkAll("after_reset", w3, 1'b1, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_RX_PARITY_EN
    // 0x06850 has five set bits, so an even-parity trailer of 1 is the good case.
    sendWord(w1, 1'b1, 0, 0, 1'b0);
    checkValue("par_good", 32'(bus.par_err), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    sendWord(w1, 1'b0, 0, 0, 1'b0);
    checkValue("par_bad", 32'(bus.par_err), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    sendWord(w1, 1'b1, 0, 0, 1'b0);
    checkValue("par_tied", 32'(bus.par_err), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(99) != 0, $urandom_range(9) < 6, 1'($urandom),
                    $urandom_range(49) == 0, $urandom_range(9) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
